// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Multi-cycle program-counter controller. Owns the PC and walks each
// instruction through a fetch handshake with instruction memory (FETCH), then
// an execute phase that the datapath gates with ex_done (EXEC). On retirement
// it resolves conditional branches and jumps, updates the PC and the taken
// flag, and counts retired instructions. A taken target that is not word
// aligned traps (TRAP). A halt request retires the current instruction and
// then stops (HALT). Both stop states are left only through rst_n.
//
// Parameters
//   RESET_PC    PC value loaded on reset. Must be word aligned.
//
// Ports
//   clk         core clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   imem_req    fetch request, high in every FETCH cycle
//   imem_addr   fetch address, always equal to pc
//   imem_ack    instruction word available; sampled only in FETCH
//   inst_valid  high in every EXEC cycle, including wait cycles
//   ex_done     datapath operands and br_op are final; sampled only in EXEC
//   br_op       branch/jump opcode
//   rs1, rs2    comparison operands
//   imm         sign-extended branch/JAL offset
//   alu_res     JALR target before bit 0 is cleared
//   halt_req    retire, then stop; sampled together with ex_done
//   pc          current PC (registered)
//   pc_plus4    pc + 4, combinational, modulo 2^32
//   taken       1 if the last retired instruction redirected the PC
//   instret     retired-instruction count, wraps modulo 2^32
//   misaligned  sticky trap flag
//   halted      sticky halt flag
// -----------------------------------------------------------------------------
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   output logic        inst_valid,
   input  logic        ex_done,
   input  logic [4:0]  br_op,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [31:0] imm,
   input  logic [31:0] alu_res,
   input  logic        halt_req,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        taken,
   output logic [31:0] instret,
   output logic        misaligned,
   output logic        halted
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_HALT  = 3'd3,
      ST_TRAP  = 3'd4
   } state_t;

   localparam logic [4:0] OP_BEQ  = 5'b00000;
   localparam logic [4:0] OP_BNE  = 5'b00001;
   localparam logic [4:0] OP_BLT  = 5'b00100;
   localparam logic [4:0] OP_BGE  = 5'b00101;
   localparam logic [4:0] OP_BLTU = 5'b00110;
   localparam logic [4:0] OP_BGEU = 5'b00111;
   localparam logic [4:0] OP_JAL  = 5'b01111;
   localparam logic [4:0] OP_JALR = 5'b10111;

   // Decides whether br_op redirects the PC. Unlisted opcodes (including the
   // 10101 "plain instruction" code) fall through and never redirect.
   function automatic logic branch_taken(
      input logic [4:0]  op,
      input logic [31:0] a,
      input logic [31:0] b
   );
      logic result;
      case (op)
         OP_BEQ:  result = (a == b);
         OP_BNE:  result = (a != b);
         OP_BLT:  result = ($signed(a) <  $signed(b));
         OP_BGE:  result = ($signed(a) >= $signed(b));
         OP_BLTU: result = (a <  b);
         OP_BGEU: result = (a >= b);
         OP_JAL:  result = 1'b1;
         OP_JALR: result = 1'b1;
         default: result = 1'b0;
      endcase
      return result;
   endfunction

   state_t      state_q,      state_d;
   logic [31:0] pc_q,         pc_d;
   logic        taken_q,      taken_d;
   logic [31:0] instret_q,    instret_d;
   logic        misaligned_q, misaligned_d;
   logic        halted_q,     halted_d;
   logic        imem_req_q,   imem_req_d;
   logic        inst_valid_q, inst_valid_d;

   logic        redirect_s;
   logic [31:0] target_s;
   logic [31:0] pc_plus4_s;
   logic        target_bad_s;

   // Branch resolution from the current operands; only consumed on ex_done.
   always_comb begin
      pc_plus4_s = pc_q + 32'd4;
      redirect_s = branch_taken(br_op, rs1, rs2);
      // JALR ignores imm and clears bit 0 of the ALU result; everything else
      // that redirects is PC-relative.
      if (br_op == OP_JALR) begin
         target_s = alu_res & 32'hFFFF_FFFE;
      end else begin
         target_s = pc_q + imm;
      end
      // A not-taken instruction falls through to pc+4, which is always
      // aligned, so only a redirect can trap.
      target_bad_s = redirect_s && (target_s[1:0] != 2'b00);
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      taken_d      = taken_q;
      instret_d    = instret_q;
      misaligned_d = misaligned_q;
      halted_d     = halted_q;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_FETCH;
         end
         ST_FETCH: begin
            if (imem_ack) begin
               state_d = ST_EXEC;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_EXEC: begin
            if (ex_done) begin
               if (target_bad_s) begin
                  // Trap wins over halt: nothing retires, architectural
                  // state stays as it was before this instruction.
                  misaligned_d = 1'b1;
                  state_d      = ST_TRAP;
               end else begin
                  if (redirect_s) begin
                     pc_d = target_s;
                  end else begin
                     pc_d = pc_plus4_s;
                  end
                  taken_d   = redirect_s;
                  instret_d = instret_q + 32'd1;
                  if (halt_req) begin
                     halted_d = 1'b1;
                     state_d  = ST_HALT;
                  end else begin
                     state_d  = ST_FETCH;
                  end
               end
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
         end
         ST_TRAP: begin
            misaligned_d = 1'b1;
            state_d      = ST_TRAP;
         end
         default: begin
            // Unreachable encodings restart the boot sequence.
            state_d = ST_IDLE;
         end
      endcase

      // Handshake outputs are registered, so they are derived from the state
      // being entered rather than the state being left.
      imem_req_d   = (state_d == ST_FETCH);
      inst_valid_d = (state_d == ST_EXEC);
   end

   // State and registered-output update; rst_n clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         taken_q      <= 1'b0;
         instret_q    <= 32'd0;
         misaligned_q <= 1'b0;
         halted_q     <= 1'b0;
         imem_req_q   <= 1'b0;
         inst_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         taken_q      <= taken_d;
         instret_q    <= instret_d;
         misaligned_q <= misaligned_d;
         halted_q     <= halted_d;
         imem_req_q   <= imem_req_d;
         inst_valid_q <= inst_valid_d;
      end
   end

   assign pc         = pc_q;
   assign imem_addr  = pc_q;
   assign pc_plus4   = pc_plus4_s;
   assign taken      = taken_q;
   assign instret    = instret_q;
   assign misaligned = misaligned_q;
   assign halted     = halted_q;
   assign imem_req   = imem_req_q;
   assign inst_valid = inst_valid_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//
// Directed bench for pc_sequencer. An instruction-level reference model tracks
// what pc, taken, instret and the sticky flags must be; one compare process
// checks every DUT output against it one time unit after each rising edge.
// Hand-computed literals at key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam logic [31:0] RST_PC = 32'h0000_0100;

   localparam int M_BOOT  = 0;
   localparam int M_FETCH = 1;
   localparam int M_EXEC  = 2;
   localparam int M_STOP  = 3;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        inst_valid;
   logic        ex_done;
   logic [4:0]  br_op;
   logic [31:0] rs1;
   logic [31:0] rs2;
   logic [31:0] imm;
   logic [31:0] alu_res;
   logic        halt_req;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic        taken;
   logic [31:0] instret;
   logic        misaligned;
   logic        halted;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   logic preload = 1'b0;

   int          m_mode;
   logic [31:0] m_pc;
   logic [31:0] m_instret;
   logic        m_taken;
   logic        m_mis;
   logic        m_halt;

   pc_sequencer #(.RESET_PC(RST_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .inst_valid (inst_valid),
      .ex_done    (ex_done),
      .br_op      (br_op),
      .rs1        (rs1),
      .rs2        (rs2),
      .imm        (imm),
      .alu_res    (alu_res),
      .halt_req   (halt_req),
      .pc         (pc),
      .pc_plus4   (pc_plus4),
      .taken      (taken),
      .instret    (instret),
      .misaligned (misaligned),
      .halted     (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running cycle counter for latency checks.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: does this opcode redirect with these operands?
   function automatic logic model_taken(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         5'd0:    return a == b;
         5'd1:    return a != b;
         5'd4:    return $signed(a) < $signed(b);
         5'd5:    return $signed(a) >= $signed(b);
         5'd6:    return a < b;
         5'd7:    return a >= b;
         5'd15:   return 1'b1;
         5'd23:   return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   // Reference: where a redirect goes (JALR rounds down to even).
   function automatic logic [31:0] model_target(input logic [4:0] op, input logic [31:0] cur,
                                                input logic [31:0] off, input logic [31:0] ar);
      if (op == 5'd23) return (ar / 32'd2) * 32'd2;
      else             return cur + off;
   endfunction

   // Instruction-level reference model.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode    <= M_BOOT;
         m_pc      <= RST_PC;
         m_taken   <= 1'b0;
         m_instret <= 32'd0;
         m_mis     <= 1'b0;
         m_halt    <= 1'b0;
      end else begin
         if (preload) m_instret <= 32'hFFFF_FFFF;
         if (m_mode == M_BOOT) begin
            m_mode <= M_FETCH;
         end else if (m_mode == M_FETCH && imem_ack) begin
            m_mode <= M_EXEC;
         end else if (m_mode == M_EXEC && ex_done) begin
            if (model_taken(br_op, rs1, rs2) && (model_target(br_op, m_pc, imm, alu_res) % 32'd4) != 32'd0) begin
               m_mis  <= 1'b1;
               m_mode <= M_STOP;
            end else begin
               m_pc      <= model_taken(br_op, rs1, rs2) ? model_target(br_op, m_pc, imm, alu_res) : m_pc + 32'd4;
               m_taken   <= model_taken(br_op, rs1, rs2);
               m_instret <= m_instret + 32'd1;
               if (halt_req) begin
                  m_halt <= 1'b1;
                  m_mode <= M_STOP;
               end else begin
                  m_mode <= M_FETCH;
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Bounded wait for the DUT to present a fetch request.
   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("fetch_req_seen", 32'(imem_req), 32'd1);
   endtask

   // One instruction: optional ack/done wait cycles, returns at the negedge
   // after the ex_done edge.
   task automatic run_instr(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] im, input logic [31:0] ar, input logic hr,
                            input int ack_wait, input int done_wait);
      wait_req();
      repeat (ack_wait) @(negedge clk);
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      br_op = op; rs1 = a; rs2 = b; imm = im; alu_res = ar;
      repeat (done_wait) @(negedge clk);
      ex_done = 1'b1; halt_req = hr;
      @(negedge clk);
      ex_done = 1'b0; halt_req = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      int c0;
      rst_n = 1'b1; imem_ack = 1'b1; ex_done = 1'b0; halt_req = 1'b0;
      br_op = 5'b10101; rs1 = 32'd0; rs2 = 32'd0; imm = 32'd0; alu_res = 32'd0;

      fork
         forever begin
            @(posedge clk);
            #1;
            chk("pc",         pc,                 m_pc);
            chk("imem_addr",  imem_addr,          m_pc);
            chk("pc_plus4",   pc_plus4,           m_pc + 32'd4);
            chk("imem_req",   32'(imem_req),      32'(m_mode == M_FETCH));
            chk("inst_valid", 32'(inst_valid),    32'(m_mode == M_EXEC));
            chk("taken",      32'(taken),         32'(m_taken));
            chk("instret",    instret,            m_instret);
            chk("misaligned", 32'(misaligned),    32'(m_mis));
            chk("halted",     32'(halted),        32'(m_halt));
         end
      join_none

      // Boot with imem_ack held high.
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h0000_0100);
      chk("rst_req", 32'(imem_req), 32'd0);
      rst_n = 1'b1;
      chk("idle_req", 32'(imem_req), 32'd0);
      @(posedge clk); #1;
      chk("boot_req", 32'(imem_req), 32'd1);
      chk("boot_addr", imem_addr, 32'h0000_0100);
      @(negedge clk);
      @(negedge clk);
      imem_ack = 1'b0; br_op = 5'b10101; ex_done = 1'b1;
      @(negedge clk);
      ex_done = 1'b0;
      chk("seq_pc1", pc, 32'h0000_0104);

      // Sequential flow, zero-wait handshakes.
      c0 = cyc;
      run_instr(5'b10101, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
      chk("seq_pc2", pc, 32'h0000_0108);
      run_instr(5'b10101, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
      chk("seq_pc3", pc, 32'h0000_010C);
      run_instr(5'b10101, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
      chk("seq_pc4", pc, 32'h0000_0110);
      chk("seq_taken", 32'(taken), 32'd0);
      chk("seq_instret", instret, 32'd4);
      chk("seq_cycles", 32'(cyc - c0), 32'd6);

      // Signed vs unsigned compare of -1 and 1.
      run_instr(5'b00100, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'd0, 1'b0, 0, 0);
      chk("blt_pc", pc, 32'h0000_0130);
      chk("blt_taken", 32'(taken), 32'd1);
      run_instr(5'b00110, 32'hFFFF_FFFF, 32'd1, 32'h20, 32'd0, 1'b0, 0, 0);
      chk("bltu_pc", pc, 32'h0000_0134);
      chk("bltu_taken", 32'(taken), 32'd0);

      // JALR clears bit 0.
      run_instr(5'b10111, 32'd0, 32'd0, 32'h40, 32'h0000_0201, 1'b0, 0, 0);
      chk("jalr_pc", pc, 32'h0000_0200);
      chk("jalr_instret", instret, 32'd7);

      // Misaligned BEQ target, with halt_req also raised: trap wins.
      run_instr(5'b00000, 32'd5, 32'd5, 32'h6, 32'd0, 1'b1, 0, 0);
      imem_ack = 1'b1;
      repeat (5) @(negedge clk);
      imem_ack = 1'b0;
      chk("trap_flag", 32'(misaligned), 32'd1);
      chk("trap_nohalt", 32'(halted), 32'd0);
      chk("trap_pc", pc, 32'h0000_0200);
      chk("trap_instret", instret, 32'd7);
      chk("trap_req", 32'(imem_req), 32'd0);

      // Reset clears the trap; then wait states and halt.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_clear_mis", 32'(misaligned), 32'd0);
      chk("rst_clear_pc", pc, 32'h0000_0100);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(5'b10101, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1, 3, 2);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_instret", instret, 32'd1);
      chk("halt_pc", pc, 32'h0000_0104);
      repeat (4) begin
         imem_ack = 1'b1; ex_done = 1'b1;
         @(negedge clk);
         imem_ack = 1'b0; ex_done = 1'b0;
         @(negedge clk);
      end
      chk("halt_stays_req", 32'(imem_req), 32'd0);
      chk("halt_stays_instret", instret, 32'd1);

      // JAL, then asynchronous reset in the middle of EXEC.
      do_reset();
      run_instr(5'b01111, 32'd0, 32'd0, 32'h8, 32'd0, 1'b0, 0, 0);
      chk("jal_pc", pc, 32'h0000_0108);
      chk("jal_taken", 32'(taken), 32'd1);
      wait_req();
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      chk("mid_exec_valid", 32'(inst_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_pc", pc, 32'h0000_0100);
      chk("async_valid", 32'(inst_valid), 32'd0);
      chk("async_taken", 32'(taken), 32'd0);
      chk("async_instret", instret, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // instret wrap from all-ones.
      wait_req();
      force dut.instret_q = 32'hFFFF_FFFF;
      preload = 1'b1;
      @(negedge clk);
      release dut.instret_q;
      preload = 1'b0;
      chk("preload_instret", instret, 32'hFFFF_FFFF);
      run_instr(5'b10101, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 0, 0);
      chk("wrap_instret", instret, 32'd0);
      chk("wrap_pc", pc, 32'h0000_0104);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
